// File: rtl/sonar_wb_hub_if.sv
// Wishbone classic slave bundle for the sonar hub; signal suffixes are
// taken from the slave's point of view.
interface sonar_wb_hub_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sonar_wb_hub.sv
// Wishbone hub for sonar channels: local control/status registers plus a
// forwarding path to N_CH channel slaves with a bounded wait.
module sonar_wb_hub #(
    parameter int N_CH      = 4,
    parameter int BUS_WIDTH = 16,
    parameter int PRE_W     = 10,
    parameter int PRE_RESET = 49,
    parameter int TIMEOUT   = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    sonar_wb_hub_if.slave             wbs,
    output logic [N_CH-1:0]           ch_valid_o,
    output logic [3:0]                ch_adr_o,
    output logic [BUS_WIDTH-1:0]      ch_dat_o,
    output logic                      ch_strb_o,
    input  logic [N_CH-1:0]           ch_ack_i,
    input  logic [N_CH*BUS_WIDTH-1:0] ch_dat_i,
    input  logic [N_CH-1:0]           cmp_i,
    output logic [PRE_W-1:0]          prescaler_o,
    output logic                      mclear_o,
    output logic [1:0]                irq_o
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCAL,
        S_FWD,
        S_ACK
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            word_q;
    logic                  wr_q;
    logic [31:0]           wdat_q;
    logic [CH_W-1:0]       ch_q;
    logic                  ack_q;
    logic [31:0]           rdata_q;
    logic [N_CH-1:0]       valid_q;
    logic [3:0]            ch_adr_q;
    logic [BUS_WIDTH-1:0]  ch_dat_q;
    logic                  ch_strb_q;

    logic [N_CH-1:0]       status_q, status_d;
    logic [N_CH-1:0]       mask_q, mask_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic                  mclear_q, mclear_d;
    logic                  tmo_q, tmo_d;
    logic [N_CH-1:0]       cmp_q;
    logic [1:0]            irq_q;

    // Bus decode, taken straight from the live request in IDLE.
    logic                  hit;
    logic [9:0]            word;
    logic                  is_local;
    logic [9:0]            w_off;
    logic                  c_ok;
    logic                  wr_stb;

    assign hit      = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:28] == 4'h3);
    assign word     = wbs.wbs_adr_i[11:2];
    assign is_local = (word < 10'd8);
    assign w_off    = word - 10'd8;
    assign c_ok     = (w_off[9:4] < 6'(N_CH));
    assign wr_stb   = wbs.wbs_we_i & wbs.wbs_sel_i[0];

    logic                        sel_ack;
    logic signed [BUS_WIDTH-1:0] sel_dat;
    logic                        tmo_hit;
    logic                        local_wr;
    logic [N_CH-1:0]             rise;
    logic [31:0]                 local_rdata;

    assign sel_ack  = ch_ack_i[ch_q];
    assign sel_dat  = ch_dat_i[int'(ch_q)*BUS_WIDTH +: BUS_WIDTH];
    assign tmo_hit  = (state_q == S_FWD) && !sel_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign local_wr = (state_q == S_LOCAL) && wr_q;
    assign rise     = cmp_i & ~cmp_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status_d    = status_q;
        mask_d      = mask_q;
        pre_d       = pre_q;
        mclear_d    = mclear_q;
        tmo_d       = tmo_q;
        local_rdata = '0;
        if (local_wr) begin
            unique case (word_q)
                3'd0:    status_d = status_q & ~wdat_q[N_CH-1:0];
                3'd1:    pre_d    = wdat_q[PRE_W-1:0];
                3'd2:    mask_d   = wdat_q[N_CH-1:0];
                3'd3: begin
                    mclear_d = wdat_q[0];
                    if (wdat_q[1]) tmo_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Hardware events are applied after software clears so a coincident set wins.
        status_d = status_d | rise;
        if (tmo_hit) tmo_d = 1'b1;
        unique case (word_q)
            3'd0:    local_rdata = 32'(status_q);
            3'd1:    local_rdata = 32'(pre_q);
            3'd2:    local_rdata = 32'(mask_q);
            3'd3:    local_rdata = {30'd0, tmo_q, mclear_q};
            3'd4:    local_rdata = 32'(cmp_i);
            default: local_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            wr_q      <= 1'b0;
            wdat_q    <= '0;
            ch_q      <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            valid_q   <= '0;
            ch_adr_q  <= '0;
            ch_dat_q  <= '0;
            ch_strb_q <= 1'b0;
            status_q  <= '0;
            mask_q    <= '0;
            pre_q     <= PRE_W'(PRE_RESET);
            mclear_q  <= 1'b0;
            tmo_q     <= 1'b0;
            cmp_q     <= '0;
            irq_q     <= '0;
        end else begin
            cmp_q    <= cmp_i;
            status_q <= status_d;
            mask_q   <= mask_d;
            pre_q    <= pre_d;
            mclear_q <= mclear_d;
            tmo_q    <= tmo_d;
            irq_q    <= {tmo_d, |(status_d & mask_d)};

            unique case (state_q)
                S_IDLE: begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    if (hit) begin
                        word_q <= word[2:0];
                        wr_q   <= wr_stb;
                        wdat_q <= wbs.wbs_dat_i;
                        if (is_local) begin
                            state_q <= S_LOCAL;
                        end else if (c_ok) begin
                            state_q             <= S_FWD;
                            cnt_q               <= '0;
                            ch_q                <= w_off[CH_W+3:4];
                            valid_q             <= '0;
                            valid_q[w_off[CH_W+3:4]] <= 1'b1;
                            ch_adr_q            <= w_off[3:0];
                            ch_dat_q            <= {wbs.wbs_dat_i[31], wbs.wbs_dat_i[BUS_WIDTH-2:0]};
                            ch_strb_q           <= wr_stb;
                        end else begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end
                    end
                end
                S_LOCAL: begin
                    rdata_q <= local_rdata;
                    ack_q   <= 1'b1;
                    state_q <= S_ACK;
                end
                S_FWD: begin
                    if (sel_ack || tmo_hit) begin
                        rdata_q   <= sel_ack ? 32'(sel_dat) : 32'd0;
                        ack_q     <= 1'b1;
                        valid_q   <= '0;
                        ch_adr_q  <= '0;
                        ch_dat_q  <= '0;
                        ch_strb_q <= 1'b0;
                        state_q   <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdata_q;
    assign ch_valid_o    = valid_q;
    assign ch_adr_o      = ch_adr_q;
    assign ch_dat_o      = ch_dat_q;
    assign ch_strb_o     = ch_strb_q;
    assign prescaler_o   = pre_q;
    assign mclear_o      = mclear_q;
    assign irq_o         = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[27:12], wbs.wbs_adr_i[1:0],
                           wbs.wbs_dat_i, wdat_q};

endmodule

// File: tb/tb_sonar_wb_hub.sv
// Randomized bench for sonar_wb_hub: a register/channel-level model predicts
// read data, latencies and side outputs for directed and random accesses.
module tb_sonar_wb_hub;

    localparam int N_CH      = 4;
    localparam int BW        = 16;
    localparam int PRE_W     = 10;
    localparam int PRE_RESET = 49;
    localparam int TIMEOUT   = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sonar_wb_hub_if wbs ();

    logic [N_CH-1:0]    ch_valid;
    logic [3:0]         ch_adr;
    logic [BW-1:0]      ch_dat_o;
    logic               ch_strb;
    logic [N_CH-1:0]    ch_ack;
    logic [N_CH*BW-1:0] ch_dat_in;
    logic [N_CH-1:0]    cmp;
    logic [PRE_W-1:0]   pre;
    logic               mclear;
    logic [1:0]         irq;

    sonar_wb_hub #(
        .N_CH(N_CH), .BUS_WIDTH(BW), .PRE_W(PRE_W), .PRE_RESET(PRE_RESET), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs),
        .ch_valid_o(ch_valid), .ch_adr_o(ch_adr), .ch_dat_o(ch_dat_o), .ch_strb_o(ch_strb),
        .ch_ack_i(ch_ack), .ch_dat_i(ch_dat_in), .cmp_i(cmp),
        .prescaler_o(pre), .mclear_o(mclear), .irq_o(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural register contents.
    int unsigned m_pre, m_mask, m_status, m_tmo, m_mclear;

    // Observations from the last transfer.
    logic [31:0]     r_dat;
    int              r_lat, r_vcyc;
    logic [N_CH-1:0] r_vseen;
    bit              r_acked;
    logic [3:0]      o_adr;
    logic [BW-1:0]   o_cdat;
    logic            o_strb;
    bit              o_stable;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pre = PRE_RESET; m_mask = 0; m_status = 0; m_tmo = 0; m_mclear = 0;
    endtask

    function automatic logic [31:0] model_read(input int w);
        case (w)
            0: return m_status;
            1: return m_pre;
            2: return m_mask;
            3: return m_tmo * 2 + m_mclear;
            4: return 32'(cmp);
            default: return 0;
        endcase
    endfunction

    task automatic model_write(input int w, input logic [31:0] d);
        case (w)
            0: m_status = m_status & ~(d % (1 << N_CH));
            1: m_pre    = d % (1 << PRE_W);
            2: m_mask   = d % (1 << N_CH);
            3: begin
                m_mclear = d % 2;
                if ((d / 2) % 2 == 1) m_tmo = 0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] sext(input logic [BW-1:0] v);
        if (v >= (1 << (BW - 1))) return 32'(v) - (32'd1 << BW);
        return 32'(v);
    endfunction

    task automatic check_side(input string tag);
        check({tag, "_pre"}, 32'(pre), m_pre);
        check({tag, "_mclear"}, 32'(mclear), m_mclear);
        check({tag, "_irq"}, 32'(irq), {m_tmo, ((m_status & m_mask) != 0)});
    endtask

    // One Wishbone access with an optional channel responder; every wait is bounded.
    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input bit we,
                        input logic [3:0] sel, input int rsp_ch, input int rsp_dly,
                        input logic [BW-1:0] rsp_dat, input int budget);
        logic [N_CH-1:0] noise;
        noise = N_CH'($urandom);
        if (rsp_ch >= 0) begin
            noise[rsp_ch] = 1'b0;
            ch_dat_in[rsp_ch*BW +: BW] = rsp_dat;
        end
        ch_ack = noise;
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
        wbs.wbs_sel_i = sel; wbs.wbs_adr_i = adr; wbs.wbs_dat_i = dat;
        r_acked = 0; r_lat = 0; r_vcyc = 0; r_vseen = '0; r_dat = '0; o_stable = 1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (|ch_valid) begin
                if (r_vcyc == 0) begin
                    o_adr = ch_adr; o_cdat = ch_dat_o; o_strb = ch_strb;
                end else if (o_adr !== ch_adr || o_cdat !== ch_dat_o || o_strb !== ch_strb) begin
                    o_stable = 0;
                end
                r_vcyc++;
                r_vseen |= ch_valid;
            end
            if (wbs.wbs_ack_o) begin
                r_acked = 1; r_lat = i; r_dat = wbs.wbs_dat_o;
                break;
            end
            if (rsp_ch >= 0 && rsp_dly > 0 && r_vcyc == rsp_dly) ch_ack[rsp_ch] = 1'b1;
        end
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        ch_ack = '0;
        tick();
        check("ack_one_cycle", 32'(wbs.wbs_ack_o), 0);
        check("dat_idle_zero", wbs.wbs_dat_o, 0);
    endtask

    task automatic local_op(input int w, input logic [31:0] dat, input bit we,
                            input logic [3:0] sel, input bit noisy);
        logic [31:0] adr, exp;
        adr = 32'h3000_0000 | (32'(w) << 2);
        if (noisy) adr = adr | ($urandom & 32'h0FFF_F003);
        exp = model_read(w);
        xfer(adr, dat, we, sel, -1, 0, '0, 20);
        check("loc_acked", 32'(r_acked), 1);
        check("loc_latency", r_lat, 2);
        check("loc_no_valid", 32'(r_vseen), 0);
        if (!we) check("loc_rdata", r_dat, exp);
        if (we && sel[0]) model_write(w, dat);
        check_side("loc");
    endtask

    // dly==0 means the channel never answers and the wait must time out.
    task automatic chan_op(input int c, input int sub, input int dly, input logic [BW-1:0] rdat,
                           input bit we, input logic [3:0] sel, input logic [31:0] dat, input bit noisy);
        logic [31:0] adr;
        adr = 32'h3000_0000 | (32'(8 + c * 16 + sub) << 2);
        if (noisy) adr = adr | ($urandom & 32'h0FFF_F003);
        xfer(adr, dat, we, sel, c, dly, rdat, TIMEOUT + 40);
        check("ch_acked", 32'(r_acked), 1);
        check("ch_vseen", 32'(r_vseen), 32'd1 << c);
        check("ch_adr", 32'(o_adr), sub);
        check("ch_wdat", 32'(o_cdat), ((dat >> 31) << (BW - 1)) | (dat & ((32'd1 << (BW - 1)) - 1)));
        check("ch_strb", 32'(o_strb), 32'(we & sel[0]));
        check("ch_stable", 32'(o_stable), 1);
        if (dly == 0) begin
            check("ch_tmo_vcyc", r_vcyc, TIMEOUT);
            check("ch_tmo_lat", r_lat, TIMEOUT + 1);
            check("ch_tmo_rdata", r_dat, 0);
            m_tmo = 1;
        end else begin
            check("ch_vcyc", r_vcyc, dly);
            check("ch_lat", r_lat, dly + 1);
            check("ch_rdata", r_dat, sext(rdat));
        end
        check_side("ch");
    endtask

    task automatic oor_op(input int c, input bit we);
        logic [31:0] adr;
        adr = 32'h3000_0000 | (32'(8 + c * 16 + int'($urandom_range(0, 15))) << 2);
        xfer(adr, $urandom, we, 4'hF, -1, 0, '0, 20);
        check("oor_acked", 32'(r_acked), 1);
        check("oor_latency", r_lat, 1);
        check("oor_rdata", r_dat, 0);
        check("oor_no_valid", 32'(r_vseen), 0);
        check_side("oor");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmp = '0; ch_ack = '0; ch_dat_in = '0;
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
        wbs.wbs_sel_i = 0; wbs.wbs_adr_i = 0; wbs.wbs_dat_i = 0;
        model_reset();
        tick(); tick();
        check("rst_ack", 32'(wbs.wbs_ack_o), 0);
        check("rst_dat", wbs.wbs_dat_o, 0);
        check("rst_valid", 32'(ch_valid), 0);
        check("rst_ch_outs", {ch_adr, ch_dat_o, 3'd0, ch_strb}, 0);
        check_side("rst");
        rst = 1'b0;
        tick();

        // Prescaler write and read-back.
        local_op(1, 32'h0000_03FF, 1, 4'h1, 0);
        check("pre_3ff", 32'(pre), 32'h3FF);
        local_op(1, 32'h0, 0, 4'hF, 0);

        // Channel 0 read with negative data, answered after three valid cycles.
        chan_op(0, 0, 3, 16'h8001, 0, 4'hF, 32'h0, 0);
        check("ch0_sext", r_dat, 32'hFFFF_8001);

        // Channel 1 silent: timeout, then clear the flag.
        chan_op(1, 0, 0, '0, 0, 4'hF, 32'h0, 0);
        check("tmo_irq1", 32'(irq[1]), 1);
        local_op(3, 32'h0, 0, 4'hF, 0);
        local_op(3, 32'h2, 1, 4'h1, 0);
        check("tmo_irq1_clr", 32'(irq[1]), 0);

        // Compare edge capture and set-beats-clear.
        local_op(2, 32'h4, 1, 4'h1, 0);
        cmp = 4'h4; tick(); cmp = 4'h0; tick(); tick();
        m_status = m_status | 4;
        check("cmp_irq0", 32'(irq[0]), 1);
        local_op(0, 32'h0, 0, 4'hF, 0);
        wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 1;
        wbs.wbs_sel_i = 4'h1; wbs.wbs_adr_i = 32'h3000_0000; wbs.wbs_dat_i = 32'h4;
        tick();
        cmp = 4'h4;
        tick();
        check("w1c_race_ack", 32'(wbs.wbs_ack_o), 1);
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
        tick();
        local_op(0, 32'h0, 0, 4'hF, 0);
        check("w1c_race_status", r_dat, 32'h4);
        local_op(0, 32'h4, 1, 4'h1, 0);
        check("w1c_status_clr", m_status, 0);
        cmp = 4'h0; tick();

        // Channel beyond N_CH and a miss outside the region.
        oor_op(8, 0);
        xfer(32'h2000_0000, 32'h0, 0, 4'hF, -1, 0, '0, 20);
        check("miss_no_ack", 32'(r_acked), 0);
        check("miss_no_valid", 32'(r_vseen), 0);

        // Randomized mix against the model.
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 11);
            if (kind <= 4) begin
                local_op($urandom_range(0, 7), $urandom, 1'($urandom), 4'($urandom), 1);
            end else if (kind <= 8) begin
                chan_op($urandom_range(0, N_CH - 1), $urandom_range(0, 15), $urandom_range(1, 6),
                        BW'($urandom), 1'($urandom), 4'($urandom), $urandom, 1);
            end else if (kind == 9) begin
                oor_op($urandom_range(N_CH, 62), 1'($urandom));
            end else begin
                xfer({4'($urandom_range(4, 15)), 28'($urandom)}, $urandom, 1'($urandom), 4'hF, -1, 0, '0, 8);
                check("rnd_miss_ack", 32'(r_acked), 0);
                check_side("rnd_miss");
            end
        end

        // Reset in the middle of a forwarded access.
        wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 1; wbs.wbs_sel_i = 4'h1;
        wbs.wbs_adr_i = 32'h3000_0000 | (32'(8 + 2 * 16) << 2); wbs.wbs_dat_i = 32'h1234;
        tick(); tick(); tick();
        check("fwd_valid_pre_rst", 32'(ch_valid), 32'h4);
        rst = 1'b1;
        tick();
        model_reset();
        check("rst_fwd_valid", 32'(ch_valid), 0);
        check("rst_fwd_ack", 32'(wbs.wbs_ack_o), 0);
        check("rst_fwd_pre", 32'(pre), PRE_RESET);
        check("rst_fwd_strb", 32'(ch_strb), 0);
        rst = 1'b0;
        wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
        r_acked = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wbs.wbs_ack_o) r_acked = 1;
        end
        check("rst_fwd_no_ack", 32'(r_acked), 0);
        local_op(2, 32'h0, 0, 4'hF, 0);
        local_op(1, 32'h0, 0, 4'hF, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
